// File: rtl/matrix_multiplier_sweep.sv
// matrix_multiplier_sweep
// Complex fixed-point product Hq = H x S_q, swept over codebook indices
// q_first..q_last against one stored H. Results are rounded half-up to
// Q fractional bits and saturated to N bits.
// Ports:
//   i_clk, i_rst                  clock; asynchronous active-high reset
//   i_start, i_keep_h             sweep request (sampled in IDLE); reuse stored H if valid
//   i_q_first, i_q_last           codebook index range, latched with i_start
//   i_h_in_valid/_r/_i, o_h_in_ready   H element stream, row-major, column index fastest
//   o_cb_addr, i_cb_r, i_cb_i     synchronous codebook ROM, address {q,k,j}, data 1 cycle later
//   o_hq_out_valid/_r/_i/_q/_last, i_hq_out_ready   result stream
//   o_busy, o_done                not idle; one-cycle completion pulse
module matrix_multiplier_sweep #(
  parameter int Q         = 8,
  parameter int N         = 16,
  parameter int ACC_WIDTH = 40,
  parameter int ROWS      = 4,
  parameter int INNER     = 4,
  parameter int COLS      = 2,
  parameter int Q_WIDTH   = 4
) (
  input  logic                                             i_clk,
  input  logic                                             i_rst,
  input  logic                                             i_start,
  input  logic                                             i_keep_h,
  input  logic [Q_WIDTH-1:0]                               i_q_first,
  input  logic [Q_WIDTH-1:0]                               i_q_last,
  input  logic                                             i_h_in_valid,
  output logic                                             o_h_in_ready,
  input  logic signed [N-1:0]                              i_h_in_r,
  input  logic signed [N-1:0]                              i_h_in_i,
  output logic [Q_WIDTH+$clog2(INNER)+$clog2(COLS)-1:0]    o_cb_addr,
  input  logic signed [N-1:0]                              i_cb_r,
  input  logic signed [N-1:0]                              i_cb_i,
  output logic                                             o_hq_out_valid,
  input  logic                                             i_hq_out_ready,
  output logic signed [N-1:0]                              o_hq_out_r,
  output logic signed [N-1:0]                              o_hq_out_i,
  output logic [Q_WIDTH-1:0]                               o_hq_out_q,
  output logic                                             o_hq_out_last,
  output logic                                             o_busy,
  output logic                                             o_done
);
  localparam int I_W  = $clog2(ROWS);
  localparam int K_W  = $clog2(INNER);
  localparam int J_W  = $clog2(COLS);
  localparam int HI_W = I_W + K_W;
  localparam int CA_W = Q_WIDTH + K_W + J_W;
  localparam logic [I_W-1:0]  L_I_LAST    = I_W'(ROWS - 1);
  localparam logic [K_W-1:0]  L_K_LAST    = K_W'(INNER - 1);
  localparam logic [J_W-1:0]  L_J_LAST    = J_W'(COLS - 1);
  localparam logic [HI_W-1:0] L_HIDX_LAST = HI_W'(ROWS * INNER - 1);
  localparam logic signed [ACC_WIDTH-1:0] L_RND = {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (Q - 1);
  localparam logic signed [ACC_WIDTH-1:0] L_MAX = {{(ACC_WIDTH-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] L_MIN = {{(ACC_WIDTH-N+1){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Exact N x N signed product; operands widened so no bits are lost.
  function automatic logic signed [2*N-1:0] f_smul(input logic signed [N-1:0] a,
                                                   input logic signed [N-1:0] b);
    logic signed [2*N-1:0] ax;
    logic signed [2*N-1:0] bx;
    ax = {{N{a[N-1]}}, a};
    bx = {{N{b[N-1]}}, b};
    f_smul = ax * bx;
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] f_sext(input logic signed [2*N:0] v);
    f_sext = {{(ACC_WIDTH-2*N-1){v[2*N]}}, v};
  endfunction

  // Round half-up to Q fractional bits, then clamp to the N-bit range.
  function automatic logic signed [N-1:0] f_sat_round(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH-1:0] sh;
    sh = (acc + L_RND) >>> Q;
    if (sh > L_MAX)      f_sat_round = L_MAX[N-1:0];
    else if (sh < L_MIN) f_sat_round = L_MIN[N-1:0];
    else                 f_sat_round = sh[N-1:0];
  endfunction

  state_t                        r_state, w_state_nxt;
  logic [Q_WIDTH-1:0]            r_q, r_q_last;
  logic [I_W-1:0]                r_i;
  logic [J_W-1:0]                r_j;
  logic [K_W-1:0]                r_k;
  logic [1:0]                    r_d;
  logic [HI_W-1:0]               r_hidx;
  logic                          r_h_loaded;
  logic [CA_W-1:0]               r_cb_addr;
  logic signed [N-1:0]           r_h_r [ROWS*INNER];
  logic signed [N-1:0]           r_h_i [ROWS*INNER];
  logic signed [N-1:0]           r_a_r, r_a_i;
  logic                          r_v1, r_f1, r_v2, r_f2;
  logic signed [ACC_WIDTH-1:0]   r_p_r, r_p_i, r_acc_r, r_acc_i;
  logic                          r_out_valid, r_out_last;
  logic signed [N-1:0]           r_out_r, r_out_i;
  logic [Q_WIDTH-1:0]            r_out_q;

  logic                          w_h_acc, w_h_last, w_k_last, w_d_last, w_elem_last, w_sweep_end;
  logic [CA_W-1:0]               w_cb_addr;
  logic signed [2*N-1:0]         w_m_rr, w_m_ii, w_m_ri, w_m_ir;
  logic signed [2*N:0]           w_p_r, w_p_i;

  assign w_h_acc     = (r_state == S_LOAD) && i_h_in_valid;
  assign w_h_last    = w_h_acc && (r_hidx == L_HIDX_LAST);
  assign w_k_last    = (r_k == L_K_LAST);
  assign w_d_last    = (r_d == 2'd2);
  assign w_elem_last = (r_i == L_I_LAST) && (r_j == L_J_LAST);
  assign w_sweep_end = w_elem_last && (r_q == r_q_last);
  assign w_cb_addr   = {r_q, r_k, r_j};

  assign w_m_rr = f_smul(r_a_r, i_cb_r);
  assign w_m_ii = f_smul(r_a_i, i_cb_i);
  assign w_m_ri = f_smul(r_a_r, i_cb_i);
  assign w_m_ir = f_smul(r_a_i, i_cb_r);
  assign w_p_r  = {w_m_rr[2*N-1], w_m_rr} - {w_m_ii[2*N-1], w_m_ii};
  assign w_p_i  = {w_m_ri[2*N-1], w_m_ri} + {w_m_ir[2*N-1], w_m_ir};

  // The address register only tracks FEED, so the port holds its last value elsewhere.
  assign o_cb_addr      = (r_state == S_FEED) ? w_cb_addr : r_cb_addr;
  assign o_h_in_ready   = (r_state == S_LOAD);
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = (r_state == S_DONE);
  assign o_hq_out_valid = r_out_valid;
  assign o_hq_out_r     = r_out_r;
  assign o_hq_out_i     = r_out_i;
  assign o_hq_out_q     = r_out_q;
  assign o_hq_out_last  = r_out_last;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_keep_h && r_h_loaded) w_state_nxt = S_FEED;
          else                        w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD:  if (w_h_last) w_state_nxt = S_FEED;  else w_state_nxt = S_LOAD;
      S_FEED:  if (w_k_last) w_state_nxt = S_DRAIN; else w_state_nxt = S_FEED;
      S_DRAIN: if (w_d_last) w_state_nxt = S_OUT;   else w_state_nxt = S_DRAIN;
      S_OUT: begin
        if (i_hq_out_ready) begin
          if (w_sweep_end) w_state_nxt = S_DONE;
          else             w_state_nxt = S_FEED;
        end else begin
          w_state_nxt = S_OUT;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sweep counters, load index and the H-valid flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q        <= {Q_WIDTH{1'b0}};
      r_q_last   <= {Q_WIDTH{1'b0}};
      r_i        <= {I_W{1'b0}};
      r_j        <= {J_W{1'b0}};
      r_k        <= {K_W{1'b0}};
      r_d        <= 2'd0;
      r_hidx     <= {HI_W{1'b0}};
      r_h_loaded <= 1'b0;
      r_cb_addr  <= {CA_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_q      <= i_q_first;
            // An inverted range collapses to the single index q_first.
            r_q_last <= (i_q_last < i_q_first) ? i_q_first : i_q_last;
            r_i      <= {I_W{1'b0}};
            r_j      <= {J_W{1'b0}};
            r_k      <= {K_W{1'b0}};
            r_d      <= 2'd0;
            r_hidx   <= {HI_W{1'b0}};
            if (!(i_keep_h && r_h_loaded)) r_h_loaded <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_h_acc) begin
            r_hidx <= r_hidx + 1'b1;
            if (w_h_last) r_h_loaded <= 1'b1;
          end
        end
        S_FEED: begin
          r_cb_addr <= w_cb_addr;
          r_k       <= w_k_last ? {K_W{1'b0}} : r_k + 1'b1;
        end
        S_DRAIN: r_d <= w_d_last ? 2'd0 : r_d + 2'd1;
        S_OUT: begin
          if (i_hq_out_ready) begin
            if (r_j == L_J_LAST) begin
              r_j <= {J_W{1'b0}};
              if (r_i == L_I_LAST) begin
                r_i <= {I_W{1'b0}};
                // Compare-terminated: q never wraps past its maximum.
                if (r_q != r_q_last) r_q <= r_q + 1'b1;
              end else begin
                r_i <= r_i + 1'b1;
              end
            end else begin
              r_j <= r_j + 1'b1;
            end
          end
        end
        S_DONE:  r_d <= 2'd0;
        default: r_d <= 2'd0;
      endcase
    end
  end

  // H storage; contents are meaningful only while r_h_loaded is set.
  always_ff @(posedge i_clk) begin
    if (w_h_acc) begin
      r_h_r[r_hidx] <= i_h_in_r;
      r_h_i[r_hidx] <= i_h_in_i;
    end
  end

  // MAC pipeline: H operand aligned with ROM data, product, accumulate.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a_r   <= {N{1'b0}};
      r_a_i   <= {N{1'b0}};
      r_v1    <= 1'b0;
      r_f1    <= 1'b0;
      r_v2    <= 1'b0;
      r_f2    <= 1'b0;
      r_p_r   <= {ACC_WIDTH{1'b0}};
      r_p_i   <= {ACC_WIDTH{1'b0}};
      r_acc_r <= {ACC_WIDTH{1'b0}};
      r_acc_i <= {ACC_WIDTH{1'b0}};
    end else begin
      r_a_r <= r_h_r[{r_i, r_k}];
      r_a_i <= r_h_i[{r_i, r_k}];
      r_v1  <= (r_state == S_FEED);
      r_f1  <= (r_k == {K_W{1'b0}});
      r_p_r <= f_sext(w_p_r);
      r_p_i <= f_sext(w_p_i);
      r_v2  <= r_v1;
      r_f2  <= r_f1;
      if (r_v2) begin
        // The first product of an element overwrites the previous sum.
        r_acc_r <= r_f2 ? r_p_r : r_acc_r + r_p_r;
        r_acc_i <= r_f2 ? r_p_i : r_acc_i + r_p_i;
      end
    end
  end

  // Result register: loaded on the last drain cycle, held until accepted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_r     <= {N{1'b0}};
      r_out_i     <= {N{1'b0}};
      r_out_q     <= {Q_WIDTH{1'b0}};
      r_out_last  <= 1'b0;
    end else if ((r_state == S_DRAIN) && w_d_last) begin
      r_out_valid <= 1'b1;
      r_out_r     <= f_sat_round(r_acc_r);
      r_out_i     <= f_sat_round(r_acc_i);
      r_out_q     <= r_q;
      r_out_last  <= w_elem_last;
    end else if ((r_state == S_OUT) && i_hq_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
